aludec_seq: RTL and testbench
=============================

// Module: aludec_seq
// PURPOSE
//  Next-generation ALU decoder for the multicycle MIPS core. Decodes aluop/funct into a 4-bit alucontrol.
//  Adds xor/nor/sltu/shift encodings and mfhi/mflo selects.
//  Owns an iterative mult/multu/div/divu sequencer with HI/LO registers.
//  Sits between the main controller FSM and the ALU/datapath; the controller stalls on busy.
// PARAMETERS
//  WIDTH  32  datapath/operand width; HI and LO are each WIDTH bits
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high reset
//  valid       in   1      issue strobe from controller; decode is qualified by valid only for mul/div start
//  aluop       in   3      controller ALU op class
//  funct       in   6      instr[5:0]
//  srca        in   WIDTH  operand A (rs)
//  srcb        in   WIDTH  operand B (rt)
//  alucontrol  out  4      ALU operation select (combinational)
//  busy        out  1      mul/div sequence in progress
//  stall       out  1      valid & busy (controller must hold the instruction)
//  done        out  1      one-cycle pulse when HI/LO have been updated
//  hi          out  WIDTH  HI register
//  lo          out  WIDTH  LO register
// BEHAVIOUR
//  Decode (comb.) aluop: 000 add=0010 | 001 sub=0110 | 011 or=0001 | 100 and=0000 | 101 slt=0111.
//   Any other aluop value means R-type (funct decode).
//  funct: 100000 add=0010, 100010 sub=0110, 100100 and=0000, 100101 or=0001, 101010 slt=0111,
//   100110 xor=0011, 100111 nor=0100, 101011 sltu=0101, 000000 sll=1000, 000010 srl=1001,
//   000011 sra=1010, 010000 mfhi=1100, 010010 mflo=1101, mult/multu/div/divu (0110xx)=1110, other=1111.
//  FSM states: IDLE, MUL, DIV, DONE. Reset (async) -> IDLE; hi=lo=0; busy=done=0; iteration count=0.
//  IDLE: start when valid & R-type & funct=0110xx. Latch |srca| and |srcb| (magnitudes only for signed ops).
//   Also latch the sign flags and op, set count=WIDTH, then go to MUL or DIV.
//  MUL: one shift-add iteration per clock; count decrements; MUL -> DONE when count hits 0.
//  DIV: one restoring-subtract iteration per clock; same exit rule.
//  Entering DONE: hi/lo written with the sign-fixed result.
//   Signed mult: negate the 2*WIDTH product if the operand signs differ.
//   Signed div: quotient sign = sa^sb; remainder sign = sa.
//  DONE: done=1 for exactly one cycle, then IDLE.
//   done is seen WIDTH+1 cycles after the issue edge (33 for WIDTH=32).
//  busy=1 in MUL, DIV and DONE. valid while busy: ignored, no restart, stall=1.
//  mfhi/mflo issued while busy therefore stall until IDLE.
//  Divide by zero (srcb==0, div or divu): full latency; lo={WIDTH{1}}, hi=srca unmodified, no sign fix.
//  Most-negative / -1 (div): lo=most-negative, hi=0. Magnitude arithmetic is WIDTH+1 bits wide to avoid overflow.
//  Reset mid-sequence: abort immediately; hi/lo return to 0; no done pulse.
//  hi/lo change only on the edge into DONE (or reset). Decode outputs are independent of FSM state.
// CONFIGURATION
//  ALUDEC_EARLY_OUT_EN defined: MUL also exits to DONE after the iteration that leaves the remaining multiplier at zero.
//   Minimum is 1 iteration. DIV is unaffected.
//  Not defined: MUL always takes exactly WIDTH iterations.
// TESTING (WIDTH=32)
//  1. aluop=010 funct=100111, then 101011, then 000011 -> alucontrol 0100, 0101, 1010; busy stays 0.
//  2. mult srca=FFFFFFFD srcb=00000007 -> done at cycle 33; hi=FFFFFFFF lo=FFFFFFEB.
//  3. divu 100/7 -> lo=0000000E hi=00000002; div FFFFFFF9/2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  4. divu srca=5 srcb=0 -> done at cycle 33; lo=FFFFFFFF hi=00000005.
//  5. mflo valid during busy -> stall=1, lo unchanged until the DONE edge. Assert reset at cycle 10 of a mult
//     -> busy=0, hi=lo=0, no done.
//  6. ALUDEC_EARLY_OUT_EN: multu 5*3 -> done at cycle 3, lo=0000000F hi=0. Without the macro -> done at cycle 33.

Source files
------------

// File: rtl/aludec_seq.sv
// aludec_seq: ALU decoder with iterative mult/div sequencer and HI/LO; ALUDEC_EARLY_OUT_EN enables multiply early exit
module aludec_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [3:0]       alucontrol,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic rtype, start, fin, sgn, sa, sb, ge, sgn_in;
  logic [CW-1:0] count;
  logic [2*WIDTH-1:0] mc, acc, prod_fix;
  logic [WIDTH-1:0] mp, araw, rem, ma, mb, q_fix, r_fix;
  logic [WIDTH:0] r2, diff;
  assign rtype = !(aluop inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101});
  assign start = valid && rtype && funct[5:2] == 4'b0110 && state == IDLE;
  assign sgn_in = !funct[0];
  assign ma = (sgn_in && srca[WIDTH-1]) ? -srca : srca;
  assign mb = (sgn_in && srcb[WIDTH-1]) ? -srcb : srcb;
  // restoring step: borrow out of the trial subtract means the divisor did not fit
  assign r2 = {rem, mp[WIDTH-1]};
  assign diff = r2 - {1'b0, mc[WIDTH-1:0]};
  assign ge = !diff[WIDTH];
  assign prod_fix = (sgn && (sa ^ sb)) ? -acc : acc;
  assign q_fix = (sgn && (sa ^ sb)) ? -mp : mp;
  assign r_fix = (sgn && sa) ? -rem : rem;
`ifdef ALUDEC_EARLY_OUT_EN
  assign fin = count == '0 || (state == MUL && mp == '0 && count != FULL);
`else
  assign fin = count == '0;
`endif
  // combinational ALU operation decode, independent of sequencer state
  always_comb begin
    alucontrol = 4'b1111;
    case (aluop)
      3'b000: alucontrol = 4'b0010;
      3'b001: alucontrol = 4'b0110;
      3'b011: alucontrol = 4'b0001;
      3'b100: alucontrol = 4'b0000;
      3'b101: alucontrol = 4'b0111;
      default:
        casez (funct)
          6'b100000: alucontrol = 4'b0010;
          6'b100010: alucontrol = 4'b0110;
          6'b100100: alucontrol = 4'b0000;
          6'b100101: alucontrol = 4'b0001;
          6'b101010: alucontrol = 4'b0111;
          6'b100110: alucontrol = 4'b0011;
          6'b100111: alucontrol = 4'b0100;
          6'b101011: alucontrol = 4'b0101;
          6'b000000: alucontrol = 4'b1000;
          6'b000010: alucontrol = 4'b1001;
          6'b000011: alucontrol = 4'b1010;
          6'b010000: alucontrol = 4'b1100;
          6'b010010: alucontrol = 4'b1101;
          6'b0110??: alucontrol = 4'b1110;
          default:   alucontrol = 4'b1111;
        endcase
    endcase
  end
  // sequencer state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // sequencer next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = funct[1] ? DIV : MUL;
      MUL:     if (fin) state_n = DONE;
      DIV:     if (fin) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // sequencer status outputs
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    stall = valid && busy;
  end
  // operand latch, iteration datapath and HI/LO update on the edge into DONE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {mc, acc, mp, araw, rem, count, sgn, sa, sb, hi, lo} <= '0;
    end else if (start) begin
      mc <= {{WIDTH{1'b0}}, funct[1] ? mb : ma};
      mp <= funct[1] ? ma : mb;
      acc <= '0;
      rem <= '0;
      araw <= srca;
      sgn <= sgn_in;
      sa <= srca[WIDTH-1];
      sb <= srcb[WIDTH-1];
      count <= FULL;
    end else if (state == MUL && !fin) begin
      acc <= acc + (mp[0] ? mc : '0);
      mc <= mc << 1;
      mp <= mp >> 1;
      count <= count - CW'(1);
    end else if (state == DIV && !fin) begin
      rem <= ge ? diff[WIDTH-1:0] : r2[WIDTH-1:0];
      mp <= {mp[WIDTH-2:0], ge};
      count <= count - CW'(1);
    end else if (state == MUL) begin
      {hi, lo} <= prod_fix;
    end else if (state == DIV) begin
      hi <= mc[WIDTH-1:0] == '0 ? araw : r_fix;
      lo <= mc[WIDTH-1:0] == '0 ? '1 : q_fix;
    end
endmodule

// File: tb/tb_aludec_seq.sv
// tb_aludec_seq: randomized self-checking bench for aludec_seq against an arithmetic reference model
module tb_aludec_seq;
  logic clk = 1'b0, reset = 1'b1, valid = 1'b0;
  logic [2:0] aluop = '0;
  logic [5:0] funct = '0;
  logic [31:0] srca = '0, srcb = '0;
  logic [3:0] alucontrol;
  logic busy, stall, done;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;

  aludec_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid(valid), .aluop(aluop), .funct(funct),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .busy(busy),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_dec(input logic [2:0] op, input logic [5:0] f);
    if (op == 3'b000) return 4'b0010;
    if (op == 3'b001) return 4'b0110;
    if (op == 3'b011) return 4'b0001;
    if (op == 3'b100) return 4'b0000;
    if (op == 3'b101) return 4'b0111;
    if (f[5:2] == 4'b0110) return 4'b1110;
    case (f)
      6'd32: return 4'b0010;
      6'd34: return 4'b0110;
      6'd36: return 4'b0000;
      6'd37: return 4'b0001;
      6'd42: return 4'b0111;
      6'd38: return 4'b0011;
      6'd39: return 4'b0100;
      6'd43: return 4'b0101;
      6'd0:  return 4'b1000;
      6'd2:  return 4'b1001;
      6'd3:  return 4'b1010;
      6'd16: return 4'b1100;
      6'd18: return 4'b1101;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic void ref_muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output int lat);
    longint sp;
    logic [63:0] up;
    int ia, ib, n;
    logic [31:0] m;
    ia = $signed(a);
    ib = $signed(b);
    lat = 33;
    case (f[1:0])
      2'd0: begin sp = longint'(ia) * longint'(ib); {h, l} = sp; end
      2'd1: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      2'd2: begin
        if (b == 0) begin l = '1; h = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = 0; end
        else begin l = ia / ib; h = ia % ib; end
      end
      default: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
    endcase
`ifdef ALUDEC_EARLY_OUT_EN
    if (!f[1]) begin
      m = (!f[0] && b[31]) ? -b : b;
      n = 0;
      while (m != 0) begin m = m >> 1; n++; end
      lat = (n == 0 ? 1 : n) + 1;
    end
`endif
  endfunction

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int lat, n;
    ref_muldiv(f, a, b, eh, el, lat);
    valid = 1'b1; aluop = 3'b010; funct = f; srca = a; srcb = b;
    @(posedge clk); #1;
    valid = 1'b0; srca = $urandom; srcb = $urandom;
    check({tag, " busy"}, busy, 1'b1);
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, n, lat);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    @(posedge clk); #1;
    check({tag, " idle"}, {done, busy}, 2'b00);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] lo0;
    int bad, n;
    #1;
    check("reset state", {busy, done, stall, hi, lo}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    aluop = 3'b010;
    funct = 6'b100111; #1; check("nor", alucontrol, 4'b0100);
    funct = 6'b101011; #1; check("sltu", alucontrol, 4'b0101);
    funct = 6'b000011; #1; check("sra", alucontrol, 4'b1010);
    check("decode busy", busy, 1'b0);
    for (int i = 0; i < 60; i++) begin
      aluop = $urandom; funct = $urandom; valid = 1'b0; #1;
      check("rand decode", alucontrol, ref_dec(aluop, funct));
    end
    run_op("mult neg", 6'b011000, 32'hFFFF_FFFD, 32'h7);
    run_op("divu 100/7", 6'b011011, 32'd100, 32'd7);
    run_op("div -7/2", 6'b011010, 32'hFFFF_FFF9, 32'd2);
    run_op("divu by0", 6'b011011, 32'd5, 32'd0);
    run_op("div by0", 6'b011010, 32'hFFFF_FFF0, 32'd0);
    run_op("div ovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("multu 5*3", 6'b011001, 32'd5, 32'd3);
    run_op("multu max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 24; i++) run_op("rand op", {4'b0110, 2'($urandom)}, pick(), pick());
    lo0 = lo;
    valid = 1'b1; aluop = 3'b010; funct = 6'b011000; srca = 32'd12; srcb = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    funct = 6'b010010; bad = 0; n = 0;
    while (!done && n < 40) begin
      if (!stall || lo !== lo0) bad++;
      if (n == 10) begin funct = 6'b011001; srca = 32'd9; srcb = 32'd9; end
      if (n == 20) funct = 6'b010010;
      @(posedge clk); #1; n++;
    end
    valid = 1'b0;
    check("stall hold", bad, 0);
    check("no restart latency", n, 33);
    check("busy result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE8);
    @(posedge clk); #1;
    valid = 1'b1; funct = 6'b011000; srca = 32'd3; srcb = 32'd4;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("reset abort", {busy, done, hi, lo}, '0);
    @(posedge clk); #1;
    reset = 1'b0; bad = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) bad++; end
    check("no done after reset", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
